// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic.
//   - Forwarding mux select encodings, matching the 3-input EX-stage operand muxes.
//   - FSM state type of the hazard unit (RUN / STALL).
//   - Default register-address width.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle of all hazard-unit signals except clock and reset.
//   master : the pipeline side; drives the ID/EX/MEM views, sees the controls.
//   slave  : the hazard unit; reads the pipeline views, drives the controls.
//
// Handshake: there is no valid/ready pair. Every input is a level sampled on
// each rising clk edge; pipe_hold is the only flow control and, when high,
// freezes all hazard-unit state for that cycle.
interface hazard_forward_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    // pipeline -> hazard unit
    logic             pipe_hold;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             mem_reg_write;
    logic             branch_taken;

    // hazard unit -> pipeline
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             stalled;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    state_t           state;      // debug view of the FSM

    modport master (
        output pipe_hold, id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
               branch_taken,
        input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble,
               ifid_flush, stalled, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  pipe_hold, id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
               branch_taken,
        output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble,
               ifid_flush, stalled, stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/fwd_select.sv
// Forwarding select for one EX-stage operand (purely combinational).
//   i_src        : source register the ID instruction reads
//   i_use        : the instruction really reads i_src
//   i_ex_rd/i_ex_reg_write   : producer in EX
//   i_mem_rd/i_mem_reg_write : producer in MEM
//   o_sel        : FWD_MEM, FWD_WB or FWD_RF
// EX is the youngest producer so it wins over MEM; $0 is never forwarded.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_reg_write,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_reg_write,
    output logic [1:0]       o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_use && i_ex_reg_write  && (i_ex_rd  == i_src) && (i_ex_rd  != '0);
    assign w_mem_hit = i_use && i_mem_reg_write && (i_mem_rd == i_src) && (i_mem_rd != '0);

    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit) begin
            o_sel = FWD_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// The instruction in ID is checked against the producers in EX and MEM.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave modport of hazard_forward_unit_if
//     fwd_a_sel/fwd_b_sel : registered into ID/EX, valid while the consumer executes
//     pc_write/ifid_write/idex_bubble/ifid_flush : combinational pipeline controls
//     stalled/state       : FSM view; stall_cnt/flush_cnt saturating event counters
// Per-cycle priority: pipe_hold > branch_taken > load-use > normal.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_forward_unit_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_lu;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_idex_bubble;
    logic             w_ifid_flush;

    logic [1:0]       r_fwd_a_sel;
    logic [1:0]       r_fwd_b_sel;
    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .i_src           (bus.id_rs),
        .i_use           (bus.id_use_rs),
        .i_ex_rd         (bus.ex_rd),
        .i_ex_reg_write  (bus.ex_reg_write),
        .i_mem_rd        (bus.mem_rd),
        .i_mem_reg_write (bus.mem_reg_write),
        .o_sel           (w_sel_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .i_src           (bus.id_rt),
        .i_use           (bus.id_use_rt),
        .i_ex_rd         (bus.ex_rd),
        .i_ex_reg_write  (bus.ex_reg_write),
        .i_mem_rd        (bus.mem_rd),
        .i_mem_reg_write (bus.mem_reg_write),
        .o_sel           (w_sel_b)
    );

    // A load in EX cannot be forwarded in time for the ID instruction's EX
    // cycle, so any real dependency on it costs one bubble.
    assign w_lu = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != '0) &&
                  ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

    // Pipeline controls; deliberately independent of rst_n.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        if (bus.pipe_hold) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
        end else if (bus.branch_taken) begin
            // The ID instruction is discarded, so a pending load-use is moot.
            w_idex_bubble = 1'b1;
            w_ifid_flush  = 1'b1;
        end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!bus.pipe_hold) begin
            if (bus.branch_taken) begin
                r_fwd_a_sel <= FWD_RF;
                r_fwd_b_sel <= FWD_RF;
                r_state     <= RUN;
                if (r_flush_cnt != CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + CNT_ONE;
                end
            end else if (w_lu) begin
                // The bubble entering ID/EX must not forward anything.
                r_fwd_a_sel <= FWD_RF;
                r_fwd_b_sel <= FWD_RF;
                r_state     <= STALL;
                if (r_stall_cnt != CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + CNT_ONE;
                end
            end else begin
                // Also the exit from STALL: the held instruction now sees the
                // load in MEM and picks FWD_WB.
                r_fwd_a_sel <= w_sel_a;
                r_fwd_b_sel <= w_sel_b;
                r_state     <= RUN;
            end
        end
    end

    assign bus.fwd_a_sel   = r_fwd_a_sel;
    assign bus.fwd_b_sel   = r_fwd_b_sel;
    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.stalled     = (r_state == STALL);
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  import pipe_pkg::*;

  localparam int TB_REG_W = 5;
  localparam int TB_CNT_W = 4;   // small so saturation is reachable quickly
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) bus ();

  hazard_forward_unit #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.pipe_hold     = 1'b0;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_use_rs     = 1'b0;
    bus.id_use_rt     = 1'b0;
    bus.ex_rd         = '0;
    bus.ex_reg_write  = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.mem_rd        = '0;
    bus.mem_reg_write = 1'b0;
    bus.branch_taken  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing $5, ID instruction reads $5 via rs.
  task automatic drive_load_use();
    clear_inputs();
    bus.ex_rd        = 5'd5;
    bus.ex_reg_write = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.id_rs        = 5'd5;
    bus.id_use_rs    = 1'b1;
    bus.id_rt        = 5'd7;
    bus.id_use_rt    = 1'b1;
  endtask

  task automatic check_ctrl(input string tag, input logic pc, input logic ifid,
                            input logic bub, input logic fl);
    check({tag, ".pc_write"},    32'(bus.pc_write),    32'(pc));
    check({tag, ".ifid_write"},  32'(bus.ifid_write),  32'(ifid));
    check({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'(bub));
    check({tag, ".ifid_flush"},  32'(bus.ifid_flush),  32'(fl));
  endtask

  task automatic check_regs(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic st);
    check({tag, ".fwd_a"},   32'(bus.fwd_a_sel), 32'(a));
    check({tag, ".fwd_b"},   32'(bus.fwd_b_sel), 32'(b));
    check({tag, ".stalled"}, 32'(bus.stalled),   32'(st));
    check({tag, ".state"},   32'(bus.state),     32'(st ? STALL : RUN));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
    check({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(exp_flush));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    #2;
    check_regs("reset", FWD_RF, FWD_RF, 1'b0);
    check_ctrl("reset_comb", 1'b1, 1'b1, 1'b0, 1'b0);
    #10 rst_n = 1'b1;   // released away from the clock edge
    tick();

    // Forward from EX/MEM on operand A.
    clear_inputs();
    bus.ex_rd = 5'd8; bus.ex_reg_write = 1'b1;
    bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    bus.id_rt = 5'd3; bus.id_use_rt = 1'b1;
    #1 check_ctrl("ex_fwd", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_regs("ex_fwd", FWD_MEM, FWD_RF, 1'b0);

    // Double hazard on rt: EX wins over MEM.
    clear_inputs();
    bus.ex_rd = 5'd9;  bus.ex_reg_write = 1'b1;
    bus.mem_rd = 5'd9; bus.mem_reg_write = 1'b1;
    bus.id_rs = 5'd2;  bus.id_use_rs = 1'b1;
    bus.id_rt = 5'd9;  bus.id_use_rt = 1'b1;
    tick();
    check_regs("double", FWD_RF, FWD_MEM, 1'b0);

    // MEM-only producer on rs; rt matches but is not used.
    clear_inputs();
    bus.mem_rd = 5'd4; bus.mem_reg_write = 1'b1;
    bus.id_rs = 5'd4;  bus.id_use_rs = 1'b1;
    bus.id_rt = 5'd4;  bus.id_use_rt = 1'b0;
    tick();
    check_regs("mem_fwd", FWD_WB, FWD_RF, 1'b0);

    // $0 is never forwarded.
    clear_inputs();
    bus.ex_rd = 5'd0;  bus.ex_reg_write = 1'b1;
    bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b1;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    tick();
    check_regs("zero_reg", FWD_RF, FWD_RF, 1'b0);

    // Load in EX but not written to a register: no stall.
    drive_load_use();
    bus.ex_reg_write = 1'b0;
    #1 check_ctrl("load_nowrite", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Load-use: one bubble, then select 01.
    drive_load_use();
    #1 check_ctrl("lu_detect", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    exp_stall = 1;
    check_regs("lu_stall", FWD_RF, FWD_RF, 1'b1);
    clear_inputs();
    bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
    bus.id_rs = 5'd5;  bus.id_use_rs = 1'b1;
    #1 check_ctrl("lu_resume", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_regs("lu_after", FWD_WB, FWD_RF, 1'b0);

    // Branch together with load-use: branch wins.
    drive_load_use();
    bus.branch_taken = 1'b1;
    #1 check_ctrl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    exp_flush = 1;
    check_regs("br_lu", FWD_RF, FWD_RF, 1'b0);

    // Hold beats branch: nothing moves.
    clear_inputs();
    bus.branch_taken = 1'b1; bus.pipe_hold = 1'b1;
    #1 check_ctrl("hold_br", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_regs("hold_br", FWD_RF, FWD_RF, 1'b0);

    // Two more branches.
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      bus.branch_taken = 1'b1;
      tick();
      exp_flush++;
      check("br_loop.flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));
    end

    // pipe_hold while in STALL for 3 cycles.
    drive_load_use();
    tick();
    exp_stall++;
    check_regs("hold_enter", FWD_RF, FWD_RF, 1'b1);
    clear_inputs();
    bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
    bus.id_rs = 5'd5;  bus.id_use_rs = 1'b1;
    bus.pipe_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_ctrl("hold_stall", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_regs("hold_stall", FWD_RF, FWD_RF, 1'b1);
    end
    bus.pipe_hold = 1'b0;
    tick();
    check_regs("hold_release", FWD_WB, FWD_RF, 1'b0);

    // Saturate the stall counter.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      drive_load_use();
      tick();
      if (exp_stall < CNT_MAX) exp_stall++;
      check("sat.stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
      clear_inputs();
      tick();
    end

    // Saturated counter frozen under hold, then async reset mid-hold.
    clear_inputs();
    bus.ex_rd = 5'd8; bus.ex_reg_write = 1'b1;
    bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    tick();
    check_regs("pre_hold", FWD_MEM, FWD_RF, 1'b0);
    bus.pipe_hold = 1'b1;
    tick();
    check_regs("hold_fwd", FWD_MEM, FWD_RF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check_regs("rst_mid_hold", FWD_RF, FWD_RF, 1'b0);
    check_ctrl("rst_comb", 1'b0, 1'b0, 1'b0, 1'b0);

    // First edge after release follows normal priority.
    drive_load_use();
    #2 rst_n = 1'b1;
    tick();
    exp_stall = 1;
    check_regs("post_rst_lu", FWD_RF, FWD_RF, 1'b1);

    // Reset during a held STALL clears the FSM.
    bus.pipe_hold = 1'b1;
    tick();
    check_regs("hold_stall2", FWD_RF, FWD_RF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_stall = 0;
    check_regs("rst_stall", FWD_RF, FWD_RF, 1'b0);
    clear_inputs();
    #2 rst_n = 1'b1;
    tick();
    check_regs("post_rst_run", FWD_RF, FWD_RF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
